// File: rtl/imem_fetch_port.sv
// Synchronous word-addressed instruction memory with valid/ready fetch, loader port and post-reset clear.
// Define IMEM_PARITY_EN to store one even-parity bit per word and flag mismatches on fetch.
module imem_fetch_port #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 7,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t              state_r;
  state_t              state_nx_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   cnt_nx_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                mem_we_s;
  logic [IDX_W-1:0]    mem_idx_s;
  logic [DATA_W-1:0]   mem_wd_s;
  logic                busy_s;
  logic                req_ready_s;
  logic                accept_s;
  logic                req_in_range_s;
  logic                ld_in_range_s;
  logic [IDX_W-1:0]    req_idx_s;
  logic [IDX_W-1:0]    ld_idx_s;
  logic                rd_par_err_s;
  logic                resp_valid_r;
  logic [DATA_W-1:0]   resp_data_r;
  logic                resp_err_r;

  assign req_in_range_s = ({1'b0, req_addr} < DEPTH_X);
  assign ld_in_range_s  = ({1'b0, ld_addr} < DEPTH_X);
  assign req_idx_s      = req_addr[IDX_W-1:0];
  assign ld_idx_s       = ld_addr[IDX_W-1:0];
  assign accept_s       = req_valid && req_ready_s;

`ifdef IMEM_PARITY_EN
  logic par_r [DEPTH];

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign rd_par_err_s = (par_r[req_idx_s] != even_parity(mem_r[req_idx_s]));

  // Parity storage, written alongside every memory word.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      par_r[mem_idx_s] <= even_parity(mem_wd_s);
    end
  end
`else
  assign rd_par_err_s = 1'b0;
`endif

  // Sequencer state and clear counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RESET_ST;
      cnt_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state, memory write port selection and handshake readiness.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    mem_we_s    = 1'b0;
    mem_idx_s   = {IDX_W{1'b0}};
    mem_wd_s    = {DATA_W{1'b0}};
    busy_s      = 1'b0;
    req_ready_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        busy_s    = 1'b1;
        mem_we_s  = 1'b1;
        mem_idx_s = cnt_r[IDX_W-1:0];
        if (cnt_r == LAST_A) begin
          state_nx_s = ST_RUN;
        end else begin
          cnt_nx_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        // Loader owns the array this cycle, so a fetch can never read a word being written.
        req_ready_s = !ld_we && (!resp_valid_r || resp_ready || flush);
        if (ld_we && ld_in_range_s) begin
          mem_we_s  = 1'b1;
          mem_idx_s = ld_idx_s;
          mem_wd_s  = ld_data;
        end else begin
          mem_we_s  = 1'b0;
        end
      end
      default: begin
        state_nx_s = RESET_ST;
        cnt_nx_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Instruction word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wd_s;
    end
  end

  // Response register: accept loads, pop or flush drains, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_W{1'b0}};
      resp_err_r   <= 1'b0;
    end else if (accept_s) begin
      resp_valid_r <= 1'b1;
      if (req_in_range_s) begin
        resp_data_r <= mem_r[req_idx_s];
        resp_err_r  <= rd_par_err_s;
      end else begin
        resp_data_r <= {DATA_W{1'b0}};
        resp_err_r  <= 1'b1;
      end
    end else if ((resp_valid_r && resp_ready) || flush) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  assign req_ready  = reset_n & req_ready_s;
  assign busy       = reset_n & busy_s;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;

endmodule
